// File: rtl/cram_prog_ctrl_if.sv
// cram_prog_ctrl_if: command/response handshake between the configuration loader and the CRAM sequencer
interface cram_prog_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_row;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_err;
    modport master (output cmd_valid, cmd_op, cmd_row, cmd_data,
                    input  cmd_ready, rsp_valid, rsp_data, rsp_err);
    modport slave  (input  cmd_valid, cmd_op, cmd_row, cmd_data,
                    output cmd_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/cram_prog_ctrl.sv
// cram_prog_ctrl: write/read/clear sequencer for one 16x4 configuration-RAM tile
module cram_prog_ctrl #(
    parameter int SETUP_CYC = 2,
    parameter int WL_CYC    = 4,
    parameter int HOLD_CYC  = 2,
    parameter int CLR_CYC   = 8
) (
    input  logic                   clk,
    input  logic                   reset_b,
    cram_prog_ctrl_if.slave        cmd,
    output logic                   busy,
    output logic                   prog,
    output logic [15:0]            wl,
    output logic [15:0]            pgate,
    output logic [15:0]            cram_reset_b,
    output logic [15:0]            vdd_cntl,
    output logic [3:0]             bl_out,
    output logic                   bl_oe,
    input  logic [3:0]             bl_in
);
    typedef enum logic [2:0] {IDLE, SETUP, WL_ON, HOLD, CLR, DONE} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic [3:0] row_q;
    logic       rd;
    logic       powered;
    always_ff @(posedge clk or negedge reset_b)
        if (!reset_b) begin
            state         <= IDLE;
            cnt           <= '0;
            row_q         <= '0;
            rd            <= 1'b0;
            powered       <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            cmd.rsp_valid <= 1'b0;
            cmd.rsp_data  <= '0;
            cmd.rsp_err   <= 1'b0;
            busy          <= 1'b0;
            prog          <= 1'b0;
            wl            <= '0;
            pgate         <= '0;
            cram_reset_b  <= 16'hFFFF;
            vdd_cntl      <= 16'hFFFF;
            bl_out        <= '0;
            bl_oe         <= 1'b0;
        end else begin
            cmd.rsp_valid <= 1'b0;
            case (state)
                IDLE:
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        cmd.cmd_ready <= 1'b0;
                        busy          <= 1'b1;
                        row_q         <= cmd.cmd_row;
                        rd            <= cmd.cmd_op == 2'b01;
                        if (cmd.cmd_op == 2'b10) begin
                            state        <= CLR;
                            cnt          <= 4'(CLR_CYC - 1);
                            powered      <= 1'b1;
                            vdd_cntl     <= 16'h0000;
                            prog         <= 1'b1;
                            cram_reset_b <= 16'h0000;
                        end else if (cmd.cmd_op == 2'b11 || !powered) begin
                            // rejected commands skip straight to a one-cycle error response
                            state         <= DONE;
                            cmd.rsp_valid <= 1'b1;
                            cmd.rsp_err   <= 1'b1;
                        end else begin
                            state  <= SETUP;
                            cnt    <= 4'(SETUP_CYC - 1);
                            prog   <= 1'b1;
                            bl_oe  <= cmd.cmd_op == 2'b00;
                            bl_out <= cmd.cmd_data;
                        end
                    end else
                        cmd.cmd_ready <= 1'b1;
                SETUP:
                    if (cnt == 4'd0) begin
                        state <= WL_ON;
                        cnt   <= 4'(WL_CYC - 1);
                        wl    <= 16'd1 << row_q;
                        pgate <= rd ? 16'd0 : 16'd1 << row_q;
                    end else
                        cnt <= cnt - 4'd1;
                WL_ON:
                    if (cnt == 4'd0) begin
                        state <= HOLD;
                        cnt   <= 4'(HOLD_CYC - 1);
                        wl    <= '0;
                        pgate <= '0;
                        if (rd) cmd.rsp_data <= bl_in;
                    end else
                        cnt <= cnt - 4'd1;
                HOLD:
                    if (cnt == 4'd0) begin
                        state         <= DONE;
                        prog          <= 1'b0;
                        bl_oe         <= 1'b0;
                        cmd.rsp_valid <= 1'b1;
                        cmd.rsp_err   <= 1'b0;
                    end else
                        cnt <= cnt - 4'd1;
                CLR:
                    if (cnt == 4'd0) begin
                        state         <= DONE;
                        prog          <= 1'b0;
                        cram_reset_b  <= 16'hFFFF;
                        cmd.rsp_valid <= 1'b1;
                        cmd.rsp_err   <= 1'b0;
                    end else
                        cnt <= cnt - 4'd1;
                DONE: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    cmd.cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_cram_prog_ctrl.sv
// tb_cram_prog_ctrl: randomized and directed checks of the CRAM sequencer against a cycle-window model
module tb_cram_prog_ctrl;
    localparam int S = 2, W = 4, H = 2, C = 8;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        busy, prog, bl_oe;
    logic [15:0] wl, pgate, cram_reset_b, vdd_cntl;
    logic [3:0]  bl_out;
    logic [3:0]  bl_in = 4'h0;
    int          total = 0, bad = 0;
    bit          m_powered = 1'b0;
    logic [3:0]  m_data = 4'h0;
    logic        m_err = 1'b0;
    cram_prog_ctrl_if c ();
    cram_prog_ctrl #(.SETUP_CYC(S), .WL_CYC(W), .HOLD_CYC(H), .CLR_CYC(C)) dut (
        .clk(clk), .reset_b(reset_b), .cmd(c), .busy(busy), .prog(prog), .wl(wl),
        .pgate(pgate), .cram_reset_b(cram_reset_b), .vdd_cntl(vdd_cntl),
        .bl_out(bl_out), .bl_oe(bl_oe), .bl_in(bl_in)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_ready(input string name);
        int t = 0;
        while (!c.cmd_ready && t < 50) begin
            tick();
            t++;
        end
        total++;
        if (!c.cmd_ready) begin
            bad++;
            $display("FAIL %s ready_timeout got=0 exp=1", name);
        end
    endtask
    // Issues one command and checks every output over the whole transaction window
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] row,
                           input logic [3:0] data, input logic [3:0] bl_val);
        bit clr, err, wr, rdc;
        int n;
        logic [68:0] act, exp;
        logic [15:0] e_wl;
        clr = op == 2'b10;
        err = op == 2'b11 || (!clr && !m_powered);
        wr  = !err && op == 2'b00;
        rdc = !err && op == 2'b01;
        n   = err ? 1 : clr ? C + 1 : S + W + H + 1;
        wait_ready(name);
        c.cmd_op = op; c.cmd_row = row; c.cmd_data = data; c.cmd_valid = 1'b1;
        tick();
        c.cmd_valid = 1'b0; c.cmd_op = 2'($urandom); c.cmd_row = 4'($urandom); c.cmd_data = 4'($urandom);
        if (clr) m_powered = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            bl_in = (k == S + W) ? bl_val : ~bl_val;
            if (rdc && k == S + W + 1) m_data = bl_val;
            if (k == n) m_err = err;
            e_wl = ((wr || rdc) && k > S && k <= S + W) ? 16'd1 << row : 16'd0;
            exp = {!err && k < n, e_wl, wr ? e_wl : 16'd0, wr && k < n,
                   (clr && k < n) ? 16'h0000 : 16'hFFFF, m_powered ? 16'h0000 : 16'hFFFF,
                   k <= n, k > n, k == n};
            act = {prog, wl, pgate, bl_oe, cram_reset_b, vdd_cntl, busy, c.cmd_ready, c.rsp_valid};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL %s ctrl k=%0d got=%h exp=%h", name, k, act, exp);
            end
            total++;
            if ({c.rsp_err, c.rsp_data} !== {m_err, m_data}) begin
                bad++;
                $display("FAIL %s rsp k=%0d got=%b/%h exp=%b/%h", name, k, c.rsp_err, c.rsp_data, m_err, m_data);
            end
            if (wr && k < n) begin
                total++;
                if (bl_out !== data) begin
                    bad++;
                    $display("FAIL %s bl_out k=%0d got=%h exp=%h", name, k, bl_out, data);
                end
            end
            tick();
        end
    endtask
    task automatic test_reset();
        c.cmd_valid = 1'b1; c.cmd_op = 2'b10; c.cmd_row = 4'h0; c.cmd_data = 4'h0;
        reset_b = 1'b0;
        repeat (3) tick();
        total++;
        if ({c.cmd_ready, c.rsp_valid, c.rsp_data, c.rsp_err, busy, prog, wl, pgate, cram_reset_b, vdd_cntl, bl_out, bl_oe}
            !== {1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got rdy=%b busy=%b prog=%b crb=%h vdd=%h", c.cmd_ready, busy, prog, cram_reset_b, vdd_cntl);
        end
        c.cmd_valid = 1'b0;
        reset_b = 1'b1;
        tick();
        total++;
        if ({c.cmd_ready, busy, vdd_cntl} !== {1'b1, 1'b0, 16'hFFFF}) begin
            bad++;
            $display("FAIL reset_idle got rdy=%b busy=%b vdd=%h exp rdy=1 busy=0 vdd=ffff", c.cmd_ready, busy, vdd_cntl);
        end
    endtask
    task automatic test_unpowered();
        run_cmd("unpowered_write", 2'b00, 4'd3, 4'hA, 4'h0);
    endtask
    task automatic test_reserved();
        run_cmd("reserved_op", 2'b11, 4'd7, 4'h5, 4'h0);
    endtask
    task automatic test_clear();
        run_cmd("clear", 2'b10, 4'd0, 4'h0, 4'h0);
    endtask
    task automatic test_write();
        run_cmd("write", 2'b00, 4'd5, 4'hA, 4'h3);
    endtask
    task automatic test_read();
        run_cmd("read", 2'b01, 4'd5, 4'h0, 4'h6);
        run_cmd("read_row15", 2'b01, 4'd15, 4'h0, 4'h9);
        run_cmd("write_row0", 2'b00, 4'd0, 4'h5, 4'h0);
    endtask
    task automatic test_back_to_back();
        int first = 0, k = 1, t = 0;
        wait_ready("b2b");
        c.cmd_op = 2'b00; c.cmd_row = 4'($urandom); c.cmd_data = 4'($urandom); c.cmd_valid = 1'b1;
        tick();
        while (first == 0 && k <= 12) begin
            if (c.cmd_ready) first = k;
            else begin
                tick();
                k++;
            end
        end
        total++;
        if (first != S + W + H + 2) begin
            bad++;
            $display("FAIL b2b next_accept got=%0d exp=%0d", first, S + W + H + 2);
        end
        tick();
        c.cmd_valid = 1'b0;
        total++;
        if ({c.cmd_ready, busy} !== 2'b01) begin
            bad++;
            $display("FAIL b2b second_accept got rdy=%b busy=%b exp rdy=0 busy=1", c.cmd_ready, busy);
        end
        while (busy && t < 20) begin
            tick();
            t++;
        end
        total++;
        if (busy || c.rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b completion got busy=%b err=%b exp busy=0 err=0", busy, c.rsp_err);
        end
        m_err = 1'b0;
    endtask
    task automatic test_random();
        logic [1:0] op;
        int r;
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 9);
            op = r < 4 ? 2'b00 : r < 7 ? 2'b01 : r < 9 ? 2'b10 : 2'b11;
            run_cmd("random", op, 4'($urandom), 4'($urandom), 4'($urandom));
        end
    endtask
    task automatic test_reset_mid();
        logic [3:0] row;
        bit seen = 1'b0;
        row = 4'($urandom);
        wait_ready("reset_mid");
        c.cmd_op = 2'b00; c.cmd_row = row; c.cmd_data = 4'hC; c.cmd_valid = 1'b1;
        tick();
        c.cmd_valid = 1'b0;
        repeat (S + 1) tick();
        total++;
        if (wl !== 16'd1 << row) begin
            bad++;
            $display("FAIL reset_mid wl_on got=%h exp=%h", wl, 16'd1 << row);
        end
        #3 reset_b = 1'b0;
        #1;
        total++;
        if ({wl, pgate, prog, bl_oe, vdd_cntl, busy, c.cmd_ready} !== {16'h0, 16'h0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid async got wl=%h pg=%h prog=%b oe=%b vdd=%h", wl, pgate, prog, bl_oe, vdd_cntl);
        end
        tick();
        reset_b = 1'b1;
        m_powered = 1'b0; m_err = 1'b0; m_data = 4'h0;
        for (int k = 0; k < 12; k++) begin
            if (c.rsp_valid) seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_mid stray_rsp got=1 exp=0");
        end
        run_cmd("post_reset_write", 2'b00, 4'd3, 4'hA, 4'h0);
    endtask
    initial begin
        c.cmd_valid = 1'b0; c.cmd_op = 2'b00; c.cmd_row = 4'h0; c.cmd_data = 4'h0;
        #1;
        test_reset();
        test_unpowered();
        test_reserved();
        test_clear();
        test_write();
        test_read();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
